alu_mc: RTL and testbench

Parametrised multi-cycle successor to the execute-stage ALU: accepts one operation per valid/ready handshake, returns a registered result with the same opcode map, and adds an iterative unsigned divider, a divide-by-zero/illegal-opcode error flag and output back-pressure. It sits between decode/register-read and the writeback/branch unit and replaces the purely combinational ALU in the execute stage.

---
 rtl/alu_mc_pkg.sv | 24 ++
 rtl/alu_div_iter.sv | 74 +++++++
 rtl/alu_mc.sv | 174 +++++++++++++++++
 tb/tb_alu_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode map, FSM state encodings and limits for the multi-cycle execute ALU.
package alu_mc_pkg;

  typedef enum int unsigned {
    OP_NOP = 0,
    OP_LV  = 1,
    OP_MLT = 2,
    OP_DIV = 3,
    OP_SUB = 4,
    OP_ADD = 5,
    OP_CP  = 6,
    OP_B   = 7,
    OP_BEG = 8,
    OP_SLL = 9,
    OP_GP  = 10
  } opcode_e;

  localparam int unsigned ILLEGAL_OP = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring unsigned divider: one quotient bit per clock after start_i.
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   trial;

  // Remainder is one bit wider so the shifted trial value never overflows.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    trial  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dsr_d  = divisor_i;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (trial >= {1'b0, dsr_q}) begin
          rem_d = trial - {1'b0, dsr_q};
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q & (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and registered results.
// Define ALU_MC_DIV_EN to build the iterative divider; otherwise opcode 3 is illegal.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 7,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  opcode,
  input  logic [RD_W-1:0]  rd,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rsi,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RD_W-1:0]  rd_out,
  output logic [RD_W-1:0]  branch_result,
  output logic [OP_W-1:0]  op_out,
  output logic [WIDTH-1:0] alu_result,
  output logic             err
);

  import alu_mc_pkg::*;

  localparam int SW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic             valid_q, valid_d;
  logic [RD_W-1:0]  rd_q, rd_d, br_q, br_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mult_c, res_c;
  logic [RD_W-1:0]  rd_c, br_c;
  logic             err_c, accept;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;

  assign mult_c   = rs * rt;
  assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

`ifdef ALU_MC_DIV_EN
  logic div_go_c;
  logic div_busy;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept & div_go_c),
    .dividend_i (rs),
    .divisor_i  (rt),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );
`else
  assign div_done = 1'b0;
  assign div_quo  = '0;
`endif

  // Single-cycle result for the presented opcode; DIV only flags that it must iterate.
  always_comb begin
    res_c = '0;
    rd_c  = '0;
    br_c  = '0;
    err_c = 1'b0;
`ifdef ALU_MC_DIV_EN
    div_go_c = 1'b0;
`endif
    case (opcode)
      OP_W'(OP_NOP): res_c = '0;
      OP_W'(OP_LV), OP_W'(OP_CP): begin res_c = rsi; rd_c = rd; end
      OP_W'(OP_MLT): begin res_c = mult_c; rd_c = rd; end
      OP_W'(OP_SUB): begin res_c = rs - rt; rd_c = rd; end
      OP_W'(OP_ADD): begin res_c = rs + rt; rd_c = rd; end
      OP_W'(OP_B):   br_c = rd;
      OP_W'(OP_BEG): begin br_c = rd; res_c = {{(WIDTH-1){1'b0}}, (rs > rt)}; end
      OP_W'(OP_SLL): begin
        rd_c  = rd;
        res_c = (rt >= WIDTH'(WIDTH)) ? '0 : (rs << rt[SW-1:0]);
      end
      OP_W'(OP_GP):  begin res_c = rs; rd_c = rd; end
`ifdef ALU_MC_DIV_EN
      OP_W'(OP_DIV): begin
        rd_c = rd;
        if (rt == '0) begin
          res_c = '1;
          err_c = 1'b1;
        end else begin
          div_go_c = 1'b1;
        end
      end
`endif
      default: err_c = 1'b1;
    endcase
  end

  // Output registers only change on an accept or a divider completion, so they hold under stall.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rd_d    = rd_q;
    br_d    = br_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          res_d   = div_quo;
        end
      end
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          rd_d    = rd_c;
          br_d    = br_c;
          op_d    = opcode;
          res_d   = res_c;
          err_d   = err_c;
`ifdef ALU_MC_DIV_EN
          if (div_go_c) begin
            state_d = ST_DIV;
            valid_d = 1'b0;
          end
`endif
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      rd_q    <= '0;
      br_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      br_q    <= br_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign out_valid     = valid_q;
  assign rd_out        = rd_q;
  assign branch_result = br_q;
  assign op_out        = op_q;
  assign alu_result    = res_q;
  assign err           = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus a randomized stream against a scoreboard.
module tb_alu_mc;

  localparam int WIDTH = 32;
  localparam int RD_W  = 7;
  localparam int OP_W  = 5;
`ifdef ALU_MC_DIV_EN
  localparam int DIV_LAT = WIDTH + 1;
`else
  localparam int DIV_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  opcode = '0;
  logic [RD_W-1:0]  rd = '0;
  logic [WIDTH-1:0] rs = '0, rsi = '0, rt = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RD_W-1:0]  rd_out, branch_result;
  logic [OP_W-1:0]  op_out;
  logic [WIDTH-1:0] alu_result;
  logic             err;

  int          assertCount = 0;
  int          failCount = 0;
  int          popCount = 0;
  logic [51:0] sbQ[$];
  logic        holdValid = 1'b0;
  logic [51:0] heldBundle = '0;
  logic [51:0] lastOut = '0;

  alu_mc #(.WIDTH(WIDTH), .RD_W(RD_W), .OP_W(OP_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .opcode        (opcode),
    .rd            (rd),
    .rs            (rs),
    .rsi           (rsi),
    .rt            (rt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .rd_out        (rd_out),
    .branch_result (branch_result),
    .op_out        (op_out),
    .alu_result    (alu_result),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Bundle layout: result[51:20], rd_out[19:13], branch[12:6], op_out[5:1], err[0].
  function automatic logic [51:0] model(input logic [4:0] op, input logic [6:0] rdv,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] imm);
    logic [31:0] res;
    logic [6:0]  r, br;
    logic        e;
    logic [63:0] p;
    res = '0; r = '0; br = '0; e = 1'b0;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      5'd0: ;
      5'd1, 5'd6: begin res = imm; r = rdv; end
      5'd2: begin res = p[31:0]; r = rdv; end
`ifdef ALU_MC_DIV_EN
      5'd3: begin r = rdv; if (b == 0) begin res = 32'hFFFF_FFFF; e = 1'b1; end else res = a / b; end
`else
      5'd3: e = 1'b1;
`endif
      5'd4: begin res = a - b; r = rdv; end
      5'd5: begin res = a + b; r = rdv; end
      5'd7: br = rdv;
      5'd8: begin br = rdv; res = (a > b) ? 32'd1 : 32'd0; end
      5'd9: begin res = (b >= 32) ? 32'd0 : (a << b); r = rdv; end
      5'd10: begin res = a; r = rdv; end
      default: e = 1'b1;
    endcase
    return {res, r, br, op, e};
  endfunction

  function automatic logic [51:0] outBundle();
    return {alu_result, rd_out, branch_result, op_out, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, then score what the next rising edge transfers.
  task automatic applyStimulus(input logic iv, input logic [4:0] op, input logic [6:0] rdv,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                               input logic ordy, output logic accepted, output logic popped);
    logic [51:0] exp;
    @(negedge clk);
    in_valid = iv; opcode = op; rd = rdv; rs = a; rt = b; rsi = imm; out_ready = ordy;
    #1;
    if (holdValid) checkOutput("hold_stable", 64'({out_valid, outBundle()}), 64'({1'b1, heldBundle}));
    popped = out_valid && out_ready;
    if (popped) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        exp = sbQ.pop_front();
        popCount++;
        lastOut = outBundle();
        checkOutput("result", 64'(lastOut), 64'(exp));
      end
    end
    holdValid  = out_valid && !out_ready;
    heldBundle = outBundle();
    accepted   = in_valid && in_ready;
    if (accepted) sbQ.push_back(model(op, rdv, a, b, imm));
  endtask

  task automatic runSingle(input logic [4:0] op, input logic [6:0] rdv, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input int expLat,
                           input string tag);
    logic acc, pop, sawReady;
    int   lat;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) applyStimulus(1'b1, op, rdv, a, b, imm, 1'b1, acc, pop);
    checkOutput({tag, "_accept"}, 64'(acc), 64'(1));
    lat = 0; pop = 1'b0; sawReady = 1'b0;
    while (!pop && lat < 200) begin
      lat++;
      applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, pop);
      if (!pop && in_ready) sawReady = 1'b1;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    if (expLat > 1) checkOutput({tag, "_busy_ready"}, 64'(sawReady), 64'(0));
  endtask

  initial begin
    logic        acc, pop;
    logic [3:0]  pat;
    int          issued, startPops;
    logic [31:0] expRes;
    logic        expErr;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_outputs", 64'({out_valid, outBundle()}), 64'(0));
    checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 64'(in_ready), 64'(1));

    runSingle(5'd5, 7'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "add_wrap");
    checkOutput("add_wrap_fields", 64'(lastOut), 64'({32'd0, 7'd5, 7'd0, 5'd5, 1'b0}));

`ifdef ALU_MC_DIV_EN
    expRes = 32'd14; expErr = 1'b0;
`else
    expRes = 32'd0; expErr = 1'b1;
`endif
    runSingle(5'd3, 7'd3, 32'd100, 32'd7, 32'd0, DIV_LAT, "div");
    checkOutput("div_result", 64'({lastOut[51:20], lastOut[0]}), 64'({expRes, expErr}));

`ifdef ALU_MC_DIV_EN
    expRes = 32'hFFFF_FFFF;
`else
    expRes = 32'd0;
`endif
    runSingle(5'd3, 7'd4, 32'd55, 32'd0, 32'd0, 1, "div_zero");
    checkOutput("div_zero_result", 64'({lastOut[51:20], lastOut[0]}), 64'({expRes, 1'b1}));

    runSingle(5'd15, 7'd9, 32'd1, 32'd2, 32'd3, 1, "illegal15");
    checkOutput("illegal15_fields", 64'(lastOut), 64'({32'd0, 7'd0, 7'd0, 5'd15, 1'b1}));

    runSingle(5'd8, 7'h12, 32'd9, 32'd3, 32'd0, 1, "beg");
    checkOutput("beg_fields", 64'(lastOut), 64'({32'd1, 7'd0, 7'h12, 5'd8, 1'b0}));

    runSingle(5'd9, 7'd6, 32'd1, 32'd40, 32'd0, 1, "sll_big");
    checkOutput("sll_big_result", 64'(lastOut[51:20]), 64'(0));

    runSingle(5'd0, 7'd6, 32'd11, 32'd12, 32'd13, 1, "nop");
    checkOutput("nop_fields", 64'(lastOut), 64'(0));

    pat = 4'b1001;
    issued = 0;
    startPops = popCount;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(issued < 4, 5'd4, 7'(c + 1), 32'(100 + 3 * c), 32'(c), 32'd0,
                    (c < 4) ? pat[c] : 1'b1, acc, pop);
      if (acc) issued++;
    end
    checkOutput("sub_stream_count", 64'(popCount - startPops), 64'(4));

    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++)
      applyStimulus(1'b1, 5'd3, 7'd2, 32'd1000, 32'd3, 32'd0, 1'b1, acc, pop);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b0, acc, pop);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs", 64'({out_valid, outBundle()}), 64'(0));
    checkOutput("midreset_in_ready", 64'(in_ready), 64'(0));
    sbQ.delete();
    holdValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("midreset_release_ready", 64'(in_ready), 64'(1));
    runSingle(5'd5, 7'd7, 32'd20, 32'd22, 32'd0, 1, "post_reset_add");
    checkOutput("post_reset_add_fields", 64'(lastOut), 64'({32'd42, 7'd7, 7'd0, 5'd5, 1'b0}));

    for (int c = 0; c < 400; c++) begin
      logic [31:0] b;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 7'($urandom),
                    32'($urandom), b, 32'($urandom), ($urandom_range(0, 3) != 0), acc, pop);
    end
    for (int c = 0; c < 200 && (sbQ.size() != 0 || out_valid); c++)
      applyStimulus(1'b0, 5'd0, 7'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, pop);
    checkOutput("drain_empty", 64'(sbQ.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
